// File: rtl/write_channel_pkg.sv
// Shared AXI4 definitions for the DMA read and write channels.
package write_channel_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  // Normal non-cacheable bufferable.
  localparam logic [3:0] AxiCacheNormalNcBuf = 4'b0011;
  localparam logic [2:0] AxiProtDefault      = 3'b000;

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry zero-bubble register slice. Upstream ready is registered, so it
// never depends combinationally on downstream ready.
module axis_reg_slice #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DataWidth-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DataWidth-1:0] o_data
);

  logic                 r_out_valid;
  logic [DataWidth-1:0] r_out_data;
  logic                 r_skid_valid;
  logic [DataWidth-1:0] r_skid_data;

  assign o_ready = ~r_skid_valid;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

  // Output stage reloads when empty or draining; otherwise an incoming beat parks in the skid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (!r_out_valid || i_ready) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= i_valid;
        if (i_valid) r_out_data <= i_data;
      end
    end else if (i_valid && !r_skid_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
    end
  end

endmodule

// File: rtl/write_channel.sv
// Single-burst AXI4 write engine: stream in, one INCR burst out, B response collected.
module write_channel
  import write_channel_pkg::*;
#(
  parameter int unsigned DMA_DATA_WIDTH_DST = 64,
  parameter int unsigned DMA_AXI_ADDR_WIDTH = 32
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_areset,
  output logic [DMA_AXI_ADDR_WIDTH-1:0]   m_s2mm_axi_awaddr,
  output logic [1:0]                      m_s2mm_axi_awburst,
  output logic [3:0]                      m_s2mm_axi_awcache,
  output logic [7:0]                      m_s2mm_axi_awlen,
  output logic [2:0]                      m_s2mm_axi_awprot,
  output logic [2:0]                      m_s2mm_axi_awsize,
  output logic                            m_s2mm_axi_awvalid,
  input  logic                            m_s2mm_axi_awready,
  output logic [DMA_DATA_WIDTH_DST-1:0]   m_s2mm_axi_wdata,
  output logic [DMA_DATA_WIDTH_DST/8-1:0] m_s2mm_axi_wstrb,
  output logic                            m_s2mm_axi_wlast,
  output logic                            m_s2mm_axi_wvalid,
  input  logic                            m_s2mm_axi_wready,
  input  logic [1:0]                      m_s2mm_axi_bresp,
  input  logic                            m_s2mm_axi_bvalid,
  output logic                            m_s2mm_axi_bready,
  input  logic [DMA_DATA_WIDTH_DST-1:0]   s_s2mm_axis_tdata,
  input  logic                            s_s2mm_axis_tvalid,
  input  logic                            s_s2mm_axis_tlast,
  output logic                            s_s2mm_axis_tready,
  input  logic                            write_start_i,
  input  logic [DMA_AXI_ADDR_WIDTH-1:0]   write_addr_i,
  input  logic [7:0]                      write_len_i,
  input  logic [2:0]                      write_size_i,
  output logic                            write_busy_o,
  output logic [1:0]                      write_resp_o,
  output logic                            write_err_o
);

  localparam int unsigned StrbWidth  = DMA_DATA_WIDTH_DST / 8;
  localparam int unsigned SliceWidth = DMA_DATA_WIDTH_DST + StrbWidth + 1;

  typedef enum logic [1:0] {StIdle, StBurst, StResp} state_e;

  state_e                          r_state, w_state_next;
  logic                            r_start_q;
  logic [DMA_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]                      r_len;
  logic [2:0]                      r_size;
  logic [7:0]                      r_beat_cnt;
  logic                            r_aw_done;
  logic                            r_pad;
  logic                            r_push_done;
  logic                            r_err;
  logic [1:0]                      r_resp;
  logic                            w_start;
  logic                            w_in_burst;
  logic                            w_aw_hs;
  logic                            w_w_hs;
  logic                            w_b_hs;
  logic                            w_push_valid;
  logic                            w_push_ready;
  logic                            w_push;
  logic                            w_push_last;
  logic [SliceWidth-1:0]           w_push_data;
  logic [SliceWidth-1:0]           w_slice_data;

  assign w_start = write_start_i & ~r_start_q & (r_state == StIdle);
  assign w_aw_hs = m_s2mm_axi_awvalid & m_s2mm_axi_awready;
  assign w_w_hs  = m_s2mm_axi_wvalid & m_s2mm_axi_wready;
  assign w_b_hs  = m_s2mm_axi_bvalid & m_s2mm_axi_bready;

  assign m_s2mm_axi_awaddr  = r_addr;
  assign m_s2mm_axi_awlen   = r_len;
  assign m_s2mm_axi_awsize  = r_size;
  assign m_s2mm_axi_awburst = BurstIncr;
  assign m_s2mm_axi_awcache = AxiCacheNormalNcBuf;
  assign m_s2mm_axi_awprot  = AxiProtDefault;
  assign m_s2mm_axi_awvalid = write_busy_o & ~r_aw_done;

  // Beats are counted as they enter the slice; order matches the W handshakes.
  assign w_push_last  = (r_beat_cnt == r_len);
  assign w_push_valid = w_in_burst & ~r_push_done & (r_pad | s_s2mm_axis_tvalid);
  assign w_push       = w_push_valid & w_push_ready;
  assign s_s2mm_axis_tready = w_in_burst & ~r_push_done & ~r_pad & w_push_ready;
  assign w_push_data  = r_pad ? {{DMA_DATA_WIDTH_DST{1'b0}}, {StrbWidth{1'b0}}, w_push_last}
                              : {s_s2mm_axis_tdata, {StrbWidth{1'b1}}, w_push_last};

  assign {m_s2mm_axi_wdata, m_s2mm_axi_wstrb, m_s2mm_axi_wlast} = w_slice_data;
  assign write_resp_o = r_resp;
  assign write_err_o  = r_err;

  axis_reg_slice #(
    .DataWidth(SliceWidth)
  ) u_slice (
    .i_clk   (m_axi_aclk),
    .i_rst   (m_axi_areset),
    .i_valid (w_push_valid),
    .o_ready (w_push_ready),
    .i_data  (w_push_data),
    .o_valid (m_s2mm_axi_wvalid),
    .i_ready (m_s2mm_axi_wready),
    .o_data  (w_slice_data)
  );

  // State register.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) r_state <= StIdle;
    else              r_state <= w_state_next;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_next      = r_state;
    w_in_burst        = 1'b0;
    write_busy_o      = 1'b0;
    m_s2mm_axi_bready = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_next = StBurst;
      end
      StBurst: begin
        w_in_burst   = 1'b1;
        write_busy_o = 1'b1;
        if (w_w_hs && m_s2mm_axi_wlast) w_state_next = StResp;
      end
      StResp: begin
        write_busy_o      = 1'b1;
        m_s2mm_axi_bready = 1'b1;
        if (w_b_hs) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Command latch, beat count, padding and error tracking.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      r_start_q   <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_beat_cnt  <= '0;
      r_aw_done   <= 1'b0;
      r_pad       <= 1'b0;
      r_push_done <= 1'b0;
      r_err       <= 1'b0;
      r_resp      <= RespOkay;
    end else begin
      r_start_q <= write_start_i;
      if (w_start) begin
        r_addr      <= write_addr_i;
        r_len       <= write_len_i;
        r_size      <= write_size_i;
        r_beat_cnt  <= '0;
        r_aw_done   <= 1'b0;
        r_pad       <= 1'b0;
        r_push_done <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_push) begin
          r_beat_cnt <= r_beat_cnt + 8'd1;
          if (w_push_last) begin
            r_push_done <= 1'b1;
            if (!r_pad && !s_s2mm_axis_tlast) r_err <= 1'b1;
          end else if (!r_pad && s_s2mm_axis_tlast) begin
            // Stream ended early: pad the rest of the burst with null beats.
            r_err <= 1'b1;
            r_pad <= 1'b1;
          end
        end
      end
      if (w_b_hs) r_resp <= m_s2mm_axi_bresp;
    end
  end

endmodule

// File: tb/tb_write_channel.sv
// Directed bench for write_channel: AXI slave/stream drivers plus a beat monitor.
module tb_write_channel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [7:0]  awlen;
  logic [2:0]  awprot, awsize;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [63:0] tdata;
  logic        tvalid, tlast, tready;
  logic        start;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        busy, err;
  logic [1:0]  resp;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit aw_hold = 0, aw_rand = 0, wr_hold = 0, wr_rand = 0;
  logic [1:0] b_cfg = 2'b00;
  bit aw_seen = 0, wl_seen = 0, b_issued = 0, b_taken = 0, busy_prev = 0;
  int aw_cnt = 0, b_cnt = 0, aw_cyc = 0, b_cyc = 0, fall_cyc = 0, s_first_cyc = 0;
  logic [31:0] aw_addr_s;
  logic [7:0]  aw_len_s;
  logic [2:0]  aw_size_s;
  logic [63:0] q_data[$];
  logic [7:0]  q_strb[$];
  logic        q_last[$];
  int          q_cyc[$];

  write_channel #(
    .DMA_DATA_WIDTH_DST(64),
    .DMA_AXI_ADDR_WIDTH(32)
  ) dut (
    .m_axi_aclk         (clk),
    .m_axi_areset       (rst),
    .m_s2mm_axi_awaddr  (awaddr),
    .m_s2mm_axi_awburst (awburst),
    .m_s2mm_axi_awcache (awcache),
    .m_s2mm_axi_awlen   (awlen),
    .m_s2mm_axi_awprot  (awprot),
    .m_s2mm_axi_awsize  (awsize),
    .m_s2mm_axi_awvalid (awvalid),
    .m_s2mm_axi_awready (awready),
    .m_s2mm_axi_wdata   (wdata),
    .m_s2mm_axi_wstrb   (wstrb),
    .m_s2mm_axi_wlast   (wlast),
    .m_s2mm_axi_wvalid  (wvalid),
    .m_s2mm_axi_wready  (wready),
    .m_s2mm_axi_bresp   (bresp),
    .m_s2mm_axi_bvalid  (bvalid),
    .m_s2mm_axi_bready  (bready),
    .s_s2mm_axis_tdata  (tdata),
    .s_s2mm_axis_tvalid (tvalid),
    .s_s2mm_axis_tlast  (tlast),
    .s_s2mm_axis_tready (tready),
    .write_start_i      (start),
    .write_addr_i       (cmd_addr),
    .write_len_i        (cmd_len),
    .write_size_i       (cmd_size),
    .write_busy_o       (busy),
    .write_resp_o       (resp),
    .write_err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AW / W ready drivers.
  initial begin
    awready = 1'b0;
    wready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      awready = aw_hold ? 1'b0 : (aw_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      wready  = wr_hold ? 1'b0 : (wr_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    end
  end

  // B responder: one response once both AW and the last W beat have gone.
  initial begin
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (bvalid && b_taken) begin
        bvalid  = 1'b0;
        b_taken = 0;
      end else if (!bvalid && aw_seen && wl_seen && !b_issued) begin
        bvalid   = 1'b1;
        bresp    = b_cfg;
        b_issued = 1;
      end
    end
  end

  // Handshake monitor, sampled mid-cycle; each handshake completes on the next rising edge.
  initial forever begin
    @(negedge clk);
    if (awvalid && awready) begin
      aw_cnt++;
      aw_seen   = 1;
      aw_cyc    = cyc;
      aw_addr_s = awaddr;
      aw_len_s  = awlen;
      aw_size_s = awsize;
    end
    if (wvalid && wready) begin
      q_data.push_back(wdata);
      q_strb.push_back(wstrb);
      q_last.push_back(wlast);
      q_cyc.push_back(cyc);
      if (wlast) wl_seen = 1;
    end
    if (bvalid && bready) begin
      b_taken = 1;
      b_cyc   = cyc;
      b_cnt++;
    end
    if (busy_prev && !busy) fall_cyc = cyc;
    busy_prev = busy;
  end

  task automatic clear_mon();
    q_data.delete();
    q_strb.delete();
    q_last.delete();
    q_cyc.delete();
    aw_cnt   = 0;
    b_cnt    = 0;
    aw_seen  = 0;
    wl_seen  = 0;
    b_issued = 0;
    b_taken  = 0;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    @(posedge clk);
    #1;
    cmd_addr = a;
    cmd_len  = l;
    cmd_size = s;
    start    = 1'b1;
    @(negedge clk);
    check_eq("awvalid_start_cycle", 64'(awvalid), 64'd0);
    @(negedge clk);
    check_eq("awvalid_next_cycle", 64'(awvalid), 64'd1);
    check_eq("busy_next_cycle", 64'(busy), 64'd1);
    start = 1'b0;
  endtask

  task automatic stream_beats(input logic [63:0] base, input int first, input int n,
                              input int last_idx, input bit rnd);
    @(posedge clk);
    #1;
    for (int i = first; i < first + n; i++) begin
      int t;
      bit hs;
      if (rnd) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin
          tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      tvalid = 1'b1;
      tdata  = base + 64'(i);
      tlast  = (i == last_idx);
      t  = 0;
      hs = 0;
      while (!hs && t < 200) begin
        @(negedge clk);
        hs = tready;
        t++;
      end
      if (i == first) s_first_cyc = cyc;
      check_eq("stream_handshake", 64'(hs), 64'd1);
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(b_cnt == 1 && busy == 1'b0) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq(tag, 64'(n < 300), 64'd1);
  endtask

  // Beats 0..real_last carry base+i with full strobes; the rest are null padding.
  task automatic check_beats(input int n_exp, input logic [63:0] base, input int real_last);
    check_eq("beat_count", 64'(q_data.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < q_data.size(); i++) begin
      check_eq($sformatf("wdata[%0d]", i), q_data[i], (i <= real_last) ? base + 64'(i) : 64'd0);
      check_eq($sformatf("wstrb[%0d]", i), 64'(q_strb[i]), (i <= real_last) ? 64'hff : 64'h0);
      check_eq($sformatf("wlast[%0d]", i), 64'(q_last[i]), 64'(i == n_exp - 1));
    end
  endtask

  initial begin
    start    = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;
    cmd_size = '0;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    tdata    = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_awvalid", 64'(awvalid), 64'd0);
    check_eq("rst_wvalid", 64'(wvalid), 64'd0);
    check_eq("rst_wlast", 64'(wlast), 64'd0);
    check_eq("rst_bready", 64'(bready), 64'd0);
    check_eq("rst_tready", 64'(tready), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_resp", 64'(resp), 64'd0);
    check_eq("rst_awaddr", 64'(awaddr), 64'd0);
    check_eq("rst_awlen", 64'(awlen), 64'd0);
    check_eq("rst_awsize", 64'(awsize), 64'd0);
    check_eq("awburst_incr", 64'(awburst), 64'd1);
    check_eq("awcache", 64'(awcache), 64'd3);
    check_eq("awprot", 64'(awprot), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Happy path.
    clear_mon();
    do_start(32'h1000, 8'd3, 3'd3);
    stream_beats(64'h1111_0000_0000_0000, 0, 4, 3, 0);
    wait_done("happy_done");
    check_beats(4, 64'h1111_0000_0000_0000, 3);
    check_eq("happy_aw_cnt", 64'(aw_cnt), 64'd1);
    check_eq("happy_awaddr", 64'(aw_addr_s), 64'h1000);
    check_eq("happy_awlen", 64'(aw_len_s), 64'd3);
    check_eq("happy_awsize", 64'(aw_size_s), 64'd3);
    if (q_cyc.size() == 4) begin
      check_eq("happy_latency", 64'(q_cyc[0] - s_first_cyc), 64'd1);
      check_eq("happy_throughput", 64'(q_cyc[3] - q_cyc[0]), 64'd3);
    end
    check_eq("happy_busy_fall", 64'(fall_cyc - b_cyc), 64'd1);
    check_eq("happy_resp", 64'(resp), 64'd0);
    check_eq("happy_err", 64'(err), 64'd0);

    // Backpressure, AW withheld until every W beat has gone.
    clear_mon();
    aw_hold = 1;
    wr_rand = 1;
    do_start(32'h2000, 8'd5, 3'd3);
    stream_beats(64'h2222_0000_0000_0000, 0, 6, 5, 1);
    for (int n = 0; n < 300 && !wl_seen; n++) @(negedge clk);
    check_eq("bp_wlast_seen", 64'(wl_seen), 64'd1);
    aw_hold = 0;
    aw_rand = 1;
    wait_done("bp_done");
    wr_rand = 0;
    aw_rand = 0;
    check_beats(6, 64'h2222_0000_0000_0000, 5);
    check_eq("bp_aw_after_w", 64'(q_cyc.size() > 0 && aw_cyc > q_cyc[$]), 64'd1);
    check_eq("bp_aw_cnt", 64'(aw_cnt), 64'd1);
    check_eq("bp_err", 64'(err), 64'd0);

    // Early tlast on beat 3 of 8.
    clear_mon();
    do_start(32'h3000, 8'd7, 3'd3);
    stream_beats(64'h3333_0000_0000_0000, 0, 3, 2, 0);
    check_eq("early_tready_pad", 64'(tready), 64'd0);
    wait_done("early_done");
    check_beats(8, 64'h3333_0000_0000_0000, 2);
    check_eq("early_err", 64'(err), 64'd1);

    // Missing tlast with a start pulse while busy.
    clear_mon();
    do_start(32'h4000, 8'd1, 3'd3);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stream_beats(64'h4444_0000_0000_0000, 0, 2, -1, 0);
    wait_done("miss_done");
    check_beats(2, 64'h4444_0000_0000_0000, 1);
    check_eq("miss_err", 64'(err), 64'd1);
    tvalid = 1'b1;
    tdata  = 64'h4444_0000_0000_0002;
    tlast  = 1'b0;
    begin
      bit held_off;
      held_off = 1;
      repeat (3) begin
        @(negedge clk);
        if (tready || busy) held_off = 0;
      end
      check_eq("miss_held_off", 64'(held_off), 64'd1);
    end
    check_eq("miss_retrig_aw_cnt", 64'(aw_cnt), 64'd1);
    clear_mon();
    do_start(32'h4100, 8'd0, 3'd3);
    wait_done("miss_next_done");
    tvalid = 1'b0;
    check_beats(1, 64'h4444_0000_0000_0002, 0);
    check_eq("miss_next_err", 64'(err), 64'd1);

    // SLVERR response.
    clear_mon();
    b_cfg = 2'b10;
    do_start(32'h5000, 8'd0, 3'd3);
    stream_beats(64'h5555_0000_0000_0000, 0, 1, 0, 0);
    wait_done("slverr_done");
    check_eq("slverr_resp", 64'(resp), 64'd2);
    check_eq("slverr_busy", 64'(busy), 64'd0);
    check_eq("slverr_err", 64'(err), 64'd0);
    b_cfg = 2'b00;

    // Asynchronous reset mid-burst.
    clear_mon();
    aw_hold = 1;
    wr_hold = 1;
    do_start(32'h6000, 8'd3, 3'd3);
    stream_beats(64'h6666_0000_0000_0000, 0, 2, -1, 0);
    @(negedge clk);
    check_eq("pre_rst_wvalid", 64'(wvalid), 64'd1);
    check_eq("pre_rst_awvalid", 64'(awvalid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_awvalid", 64'(awvalid), 64'd0);
    check_eq("arst_wvalid", 64'(wvalid), 64'd0);
    check_eq("arst_tready", 64'(tready), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_bready", 64'(bready), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    aw_hold = 0;
    wr_hold = 0;
    clear_mon();
    do_start(32'h7000, 8'd0, 3'd2);
    stream_beats(64'h7777_0000_0000_0000, 0, 1, 0, 0);
    wait_done("post_rst_done");
    check_beats(1, 64'h7777_0000_0000_0000, 0);
    check_eq("post_rst_awaddr", 64'(aw_addr_s), 64'h7000);
    check_eq("post_rst_awsize", 64'(aw_size_s), 64'd2);
    check_eq("post_rst_resp", 64'(resp), 64'd0);
    check_eq("post_rst_err", 64'(err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
